sq_serial: RTL

- Sequential integer squarer with valid/ready handshakes on both sides.
- Inverse companion to the pipelined square-root block: takes a UQ<WIDTH>.0 value and returns its exact square as UQ<2*WIDTH>.0.
- Sits in the same arithmetic datapath. Used to regenerate squared magnitudes and to cross-check square-root results (sqrt(x)^2 vs x).
- Area-lean radix-2 shift-add implementation: one multiplier bit per clock.

---
 rtl/sq_pkg.sv | 17 +
 rtl/sq_serial.sv | 111 +++++++++++
 2 files changed

// File: rtl/sq_pkg.sv
// Shared types and helpers for the serial squarer.
package sq_pkg;

   localparam int SQ_DEFAULT_WIDTH = 32;

   typedef enum logic [1:0] {
      SQ_IDLE = 2'd0,
      SQ_BUSY = 2'd1,
      SQ_DONE = 2'd2
   } sq_state_e;

   // The step counter has to reach WIDTH itself, hence WIDTH+1 codes.
   function automatic int sq_cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/sq_serial.sv
// Radix-2 shift-add squarer: UQ<WIDTH>.0 in, exact UQ<2*WIDTH>.0 square out.
// One multiplier bit is retired per clock. Latency is fixed at WIDTH clocks
// from the accepting edge to source_valid, independent of the operand value.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | sink_ready=1, waiting for an operand
//   BUSY    | WIDTH shift-add steps in progress, sink ignored
//   DONE    | result held on source until source_ready is seen
//
// Handshake outputs are decoded from the registered state only, so there is
// no combinational path from sink_valid or source_ready to any output.
module sq_serial
   import sq_pkg::*;
#(
   parameter int WIDTH = SQ_DEFAULT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [WIDTH-1:0]     sink,
   input  logic                 sink_valid,
   output logic                 sink_ready,
   output logic [2*WIDTH-1:0]   source,
   output logic                 source_valid,
   input  logic                 source_ready
);

   localparam int               CW   = sq_cnt_width(WIDTH);
   localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);

   sq_state_e              state_q,  state_d;
   logic [2*WIDTH-1:0]     mcand_q,  mcand_d;
   logic [WIDTH-1:0]       mplier_q, mplier_d;
   logic [2*WIDTH-1:0]     acc_q,    acc_d;
   logic [CW-1:0]          cnt_q,    cnt_d;
   logic [2*WIDTH-1:0]     source_q, source_d;
   logic [2*WIDTH-1:0]     acc_step;

   // Conditional add of the shifted multiplicand for the current multiplier bit.
   always_comb begin
      acc_step = acc_q;
      if (mplier_q[0]) begin
         acc_step = acc_q + mcand_q;
      end
   end

   // Next-state and datapath update for the IDLE/BUSY/DONE sequence.
   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      source_d = source_q;
      case (state_q)
         SQ_IDLE: begin
            if (sink_valid) begin
               mcand_d  = {{WIDTH{1'b0}}, sink};
               mplier_d = sink;
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = SQ_BUSY;
            end
         end
         SQ_BUSY: begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            // The last step's sum goes straight to the output register.
            if (cnt_q == LAST) begin
               source_d = acc_step;
               state_d  = SQ_DONE;
            end
         end
         SQ_DONE: begin
            // source keeps its value after handoff; it is don't-care while invalid.
            if (source_ready) begin
               state_d = SQ_IDLE;
            end
         end
         default: begin
            state_d = SQ_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any computation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= SQ_IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         source_q <= '0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         source_q <= source_d;
      end
   end

   assign sink_ready   = (state_q == SQ_IDLE);
   assign source_valid = (state_q == SQ_DONE);
   assign source       = source_q;

endmodule
